// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-division generator.
package clk_div_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // A zero ratio is treated as divide-by-one.
    function automatic int unsigned eff_div_f(input int unsigned div);
        return (div == 0) ? 1 : div;
    endfunction

    // A phase at or beyond the ratio is clamped to the last counter value.
    function automatic int unsigned eff_ph_f(input int unsigned div, input int unsigned phase);
        int unsigned ed;
        ed = eff_div_f(div);
        return (phase >= ed) ? ed - 1 : phase;
    endfunction

    // Width of the settle counter, which counts 0 .. lock_cycles-1.
    function automatic int unsigned settle_w_f(input int unsigned lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: shadow config, phase counter and registered output decode.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DEF_DIV   = 4,
    parameter int DEF_PHASE = 0
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    input  logic             locked_state,
    output logic             clkout,
    output logic             clk_en
);

    localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] RST_PHASE = DIV_W'(DEF_PHASE);
    localparam logic [DIV_W-1:0] RST_PH    = DIV_W'(eff_ph_f(DEF_DIV, DEF_PHASE));

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] eff_ph;
    logic [DIV_W-1:0] new_ph;
    logic [DIV_W:0]   high_lim;
    logic             cnt_last;

    // Clamp the stored and incoming settings; high_lim rounds up so odd ratios stay high one extra cycle.
    always_comb begin
        eff_div  = DIV_W'(eff_div_f(32'(div_q)));
        eff_ph   = DIV_W'(eff_ph_f(32'(div_q), 32'(phase_q)));
        new_ph   = DIV_W'(eff_ph_f(32'(cfg_div), 32'(cfg_phase)));
        high_lim = ({1'b0, eff_div} + 1'b1) >> 1;
        cnt_last = (cnt == eff_div - 1'b1);
    end

    // Shadow capture and phase counter: hold at the phase while settling, wrap at eff_div-1 once locked.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= RST_DIV;
            phase_q <= RST_PHASE;
            cnt     <= RST_PH;
        end else if (cfg_load) begin
            div_q   <= cfg_div;
            phase_q <= cfg_phase;
            cnt     <= new_ph;
        end else if (!locked_state) begin
            cnt <= eff_ph;
        end else if (cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered decode; a load edge forces both outputs low on the following cycle.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            clkout <= 1'b0;
            clk_en <= 1'b0;
        end else begin
            clkout <= locked_state & ~cfg_load & ({1'b0, cnt} < high_lim);
            clk_en <= locked_state & ~cfg_load & (cnt == '0);
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// Clock-division generator: settle/lock state machine plus NUM_CH independent divider channels.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 100,
    parameter int DEF_DIV     = 4,
    parameter int DEF_PHASE   = 0
) (
    input  logic                    clkin,
    input  logic                    rst_n,
    input  logic                    cfg_load,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
    output logic [NUM_CH-1:0]       clkout,
    output logic [NUM_CH-1:0]       clk_en,
    output logic                    locked
);

    localparam int              SW          = settle_w_f(LOCK_CYCLES);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(LOCK_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] settle_cnt;
    logic [SW-1:0] settle_cnt_nx;
    logic          locked_nx;
    logic          locked_state;

    assign locked_state = (state == LOCKED);

    // State, settle counter and locked flag registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
            locked     <= locked_nx;
        end
    end

    // Next state: any load restarts the full settle count; settle ends after LOCK_CYCLES edges.
    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        locked_nx     = locked;
        if (cfg_load) begin
            state_nx      = SETTLE;
            settle_cnt_nx = '0;
            locked_nx     = 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nx      = LOCKED;
                        settle_cnt_nx = '0;
                        locked_nx     = 1'b1;
                    end else begin
                        settle_cnt_nx = settle_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    locked_nx = 1'b1;
                end
                default: begin
                    state_nx      = SETTLE;
                    settle_cnt_nx = '0;
                    locked_nx     = 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clk_div_ch #(
            .DIV_W     (DIV_W),
            .DEF_DIV   (DEF_DIV),
            .DEF_PHASE (DEF_PHASE)
        ) u_ch (
            .clkin        (clkin),
            .rst_n        (rst_n),
            .cfg_load     (cfg_load),
            .cfg_div      (cfg_div[gi*DIV_W +: DIV_W]),
            .cfg_phase    (cfg_phase[gi*DIV_W +: DIV_W]),
            .locked_state (locked_state),
            .clkout       (clkout[gi]),
            .clk_en       (clk_en[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen against an arithmetic model of lock timing and output phase.
module tb_clk_div_gen;

    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 8;
    localparam int LOCK_CYCLES = 100;
    localparam int DEF_DIV     = 4;
    localparam int DEF_PHASE   = 0;
    localparam int W           = 1 + 2 * NUM_CH;

    logic                    clkin;
    logic                    rst_n;
    logic                    cfg_load;
    logic [NUM_CH*DIV_W-1:0] cfg_div;
    logic [NUM_CH*DIV_W-1:0] cfg_phase;
    logic [NUM_CH-1:0]       clkout;
    logic [NUM_CH-1:0]       clk_en;
    logic                    locked;

    int n_checks;
    int n_fail;
    logic [W-1:0] exp_q[$];

    // Model state: edges since reset release or the last load edge, plus the shadow settings.
    int t;
    int sdiv[NUM_CH];
    int sph[NUM_CH];

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEF_DIV     (DEF_DIV),
        .DEF_PHASE   (DEF_PHASE)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .clkout    (clkout),
        .clk_en    (clk_en),
        .locked    (locked)
    );

    // Clock and watchdog
    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {locked, clkout, clk_en} after edge t: locked once t reaches LOCK_CYCLES; outputs
    // reflect counter position j = t-1-LOCK_CYCLES cycles into the locked period.
    function automatic logic [W-1:0] model_out();
        logic              lk;
        logic [NUM_CH-1:0] co;
        logic [NUM_CH-1:0] ce;
        int ed, ep, pos;
        lk = (t >= LOCK_CYCLES);
        co = '0;
        ce = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ed = (sdiv[ch] == 0) ? 1 : sdiv[ch];
            ep = (sph[ch] >= ed) ? ed - 1 : sph[ch];
            if (t >= LOCK_CYCLES + 1) begin
                pos    = (ep + t - 1 - LOCK_CYCLES) % ed;
                co[ch] = (pos < (ed + 1) / 2);
                ce[ch] = (pos == 0);
            end
        end
        return {lk, co, ce};
    endfunction

    function automatic logic [NUM_CH*DIV_W-1:0] pk(input int v0, input int v1);
        return {DIV_W'(v1), DIV_W'(v0)};
    endfunction

    task automatic model_defaults();
        t = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sdiv[ch] = DEF_DIV;
            sph[ch]  = DEF_PHASE;
        end
    endtask

    // Driver: present inputs, advance one edge, update model, compare at the falling edge.
    task automatic tick(input logic load, input logic [NUM_CH*DIV_W-1:0] d,
                        input logic [NUM_CH*DIV_W-1:0] p);
        logic [W-1:0] e;
        cfg_load  = load;
        cfg_div   = d;
        cfg_phase = p;
        @(posedge clkin);
        if (load) begin
            t = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sdiv[ch] = int'(d[ch*DIV_W +: DIV_W]);
                sph[ch]  = int'(p[ch*DIV_W +: DIV_W]);
            end
        end else begin
            t++;
        end
        exp_q.push_back(model_out());
        @(negedge clkin);
        cfg_load = 1'b0;
        e = exp_q.pop_front();
        check("locked", 32'(locked), 32'(e[W-1]));
        check("clkout", 32'(clkout), 32'(e[2*NUM_CH-1:NUM_CH]));
        check("clk_en", 32'(clk_en), 32'(e[NUM_CH-1:0]));
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b0, cfg_div, cfg_phase);
    endtask

    task automatic load(input int d0, input int d1, input int p0, input int p1);
        tick(1'b1, pk(d0, d1), pk(p0, p1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_clkout"}, 32'(clkout), 32'd0);
        check({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    endtask

    initial begin
        int d0, d1;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cfg_load  = 1'b0;
        cfg_div   = '0;
        cfg_phase = '0;
        model_defaults();

        // Reset state, then release on a falling edge and lock with defaults.
        repeat (2) @(negedge clkin);
        check_zero("reset");
        rst_n = 1'b1;
        model_defaults();
        run(130);

        // Relative phase between channels held over a long run.
        load(4, 4, 0, 2);
        run(1100);

        // Odd and degenerate ratios.
        load(5, 1, 0, 0);
        run(130);
        load(0, 2, 0, 1);
        run(130);

        // Phase clamp and maximum ratio.
        load(3, 255, 7, 254);
        run(650);

        // Repeated loads during settle restart the count.
        load(6, 7, 1, 3);
        run(49);
        load(3, 9, 0, 8);
        run(98);
        load(2, 5, 1, 4);
        run(120);

        // Randomised configurations with random dwell, some reloading mid-settle.
        for (int i = 0; i < 12; i++) begin
            d0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            d1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            load(d0, d1, $urandom_range(0, 255), $urandom_range(0, 12));
            run($urandom_range(1, 400));
        end

        // Asynchronous reset between edges while locked.
        load(3, 5, 1, 2);
        run(150);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clkin);
        check_zero("in_rst");
        rst_n = 1'b1;
        model_defaults();
        run(130);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
